// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - memory-access pipeline stage driving a req/ack data memory with byte enables
// Build option MEM_ALIGN_CHK_EN: trap misaligned accesses (align_exc_o) instead of forcing alignment.
module mem_stage_hs #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic                cregwa_i,
    input  logic [1:0]          cregwd_i,
    input  logic                regwe_i,
    input  logic                memwe_i,
    input  logic                memre_i,
    input  logic                memsign_i,
    input  logic [1:0]          memlen_i,
    input  logic [DATA_W-1:0]   rd2_i,
    input  logic [DATA_W-1:0]   aluout_i,
    input  logic [REG_AW-1:0]   rt_i,
    input  logic [REG_AW-1:0]   rd_i,
    output logic                mreq_o,
    output logic                mwe_o,
    output logic [DATA_W-1:0]   maddr_o,
    output logic [DATA_W-1:0]   mwdata_o,
    output logic [DATA_W/8-1:0] mbe_o,
    input  logic                mack_i,
    input  logic [DATA_W-1:0]   mrdata_i,
    output logic                stall_o,
    output logic                we_me,
    output logic [REG_AW-1:0]   wa_me,
    output logic [DATA_W-1:0]   wd_me,
    output logic                valid_o,
    output logic                regwe_o,
    output logic [1:0]          cregwd_o,
    output logic [REG_AW-1:0]   wa_o,
    output logic [DATA_W-1:0]   aluout_o,
    output logic [DATA_W-1:0]   memrd_o
`ifdef MEM_ALIGN_CHK_EN
    ,
    output logic                align_exc_o
`endif
);
    localparam int NB = DATA_W / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    state_t state, state_n;

    logic [REG_AW-1:0] wa;
    logic [OB-1:0]     off_raw, off, size_m1;
    logic              mem_op, misal, go, in_access, sign_bit;
    logic [DATA_W-1:0] addr_c, wdata_c, shifted, ld_val, load_buf;
    logic [NB-1:0]     be_c;

    assign wa      = cregwa_i ? rd_i : rt_i;
    assign mem_op  = valid_i & (memre_i | memwe_i);
    assign off_raw = aluout_i[OB-1:0];

    // size_m1 is (bytes - 1); dword collapses to word on a 32-bit datapath
    always_comb begin
        case (memlen_i)
            2'b00:   size_m1 = OB'(0);
            2'b01:   size_m1 = OB'(1);
            2'b11:   size_m1 = {OB{1'b1}};
            default: size_m1 = OB'(3);
        endcase
    end

`ifdef MEM_ALIGN_CHK_EN
    assign misal = mem_op & (|(off_raw & size_m1));
`else
    assign misal = 1'b0;
`endif
    assign off    = off_raw & ~size_m1;
    assign go     = mem_op & ~misal;
    assign addr_c = {aluout_i[DATA_W-1:OB], {OB{1'b0}}};

    always_comb begin
        be_c     = '0;
        wdata_c  = '0;
        ld_val   = '0;
        shifted  = mrdata_i >> {off, 3'b000};
        sign_bit = memsign_i & shifted[{size_m1, 3'b111}];
        for (int i = 0; i < NB; i++) begin
            be_c[i]           = ((OB'(i) & ~size_m1) == off);
            wdata_c[8*i +: 8] = rd2_i[{OB'(i) & size_m1, 3'b000} +: 8];
            ld_val[8*i +: 8]  = (OB'(i) <= size_m1) ? shifted[8*i +: 8] : {8{sign_bit}};
        end
    end

    // request fields are only driven while the access is outstanding
    assign in_access = (state == S_ACCESS);
    assign mreq_o    = in_access;
    assign mwe_o     = in_access & memwe_i;
    assign maddr_o   = in_access ? addr_c : '0;
    assign mwdata_o  = in_access ? wdata_c : '0;
    assign mbe_o     = in_access ? be_c : '0;

    assign we_me = valid_i & regwe_i & ~(memre_i & (state != S_DONE));
    assign wa_me = wa;
    always_comb begin
        case (cregwd_i)
            2'b00:   wd_me = aluout_i;
            2'b01:   wd_me = load_buf;
            default: wd_me = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        stall_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_n = S_ACCESS;
                    stall_o = 1'b1;
                end
            end
            S_ACCESS: begin
                stall_o = 1'b1;
                if (mack_i) state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            load_buf <= '0;
            valid_o  <= 1'b0;
            regwe_o  <= 1'b0;
            cregwd_o <= '0;
            wa_o     <= '0;
            aluout_o <= '0;
            memrd_o  <= '0;
`ifdef MEM_ALIGN_CHK_EN
            align_exc_o <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (in_access && mack_i && memre_i) load_buf <= ld_val;
            if (stall_o) begin
                valid_o <= 1'b0;
                regwe_o <= 1'b0;
`ifdef MEM_ALIGN_CHK_EN
                align_exc_o <= 1'b0;
`endif
            end else begin
                valid_o  <= valid_i;
                regwe_o  <= valid_i & regwe_i & ~misal;
                cregwd_o <= cregwd_i;
                wa_o     <= wa;
                aluout_o <= aluout_i;
                memrd_o  <= load_buf;
`ifdef MEM_ALIGN_CHK_EN
                align_exc_o <= misal;
`endif
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - scoreboard testbench for mem_stage_hs (32-bit datapath)
module tb_mem_stage_hs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid_i, cregwa_i, regwe_i, memwe_i, memre_i, memsign_i;
    logic [1:0]  cregwd_i, memlen_i;
    logic [31:0] rd2_i, aluout_i, mrdata_i;
    logic [4:0]  rt_i, rd_i;
    logic        mreq_o, mwe_o, mack_i, stall_o, we_me, valid_o, regwe_o;
    logic [31:0] maddr_o, mwdata_o, wd_me, aluout_o, memrd_o;
    logic [3:0]  mbe_o;
    logic [4:0]  wa_me, wa_o;
    logic [1:0]  cregwd_o;
`ifdef MEM_ALIGN_CHK_EN
    logic        align_exc_o;
`endif

    mem_stage_hs #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .cregwa_i(cregwa_i), .cregwd_i(cregwd_i),
        .regwe_i(regwe_i), .memwe_i(memwe_i), .memre_i(memre_i), .memsign_i(memsign_i),
        .memlen_i(memlen_i), .rd2_i(rd2_i), .aluout_i(aluout_i), .rt_i(rt_i), .rd_i(rd_i),
        .mreq_o(mreq_o), .mwe_o(mwe_o), .maddr_o(maddr_o), .mwdata_o(mwdata_o), .mbe_o(mbe_o),
        .mack_i(mack_i), .mrdata_i(mrdata_i), .stall_o(stall_o), .we_me(we_me), .wa_me(wa_me),
        .wd_me(wd_me), .valid_o(valid_o), .regwe_o(regwe_o), .cregwd_o(cregwd_o), .wa_o(wa_o),
        .aluout_o(aluout_o), .memrd_o(memrd_o)
`ifdef MEM_ALIGN_CHK_EN
        , .align_exc_o(align_exc_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_t;
    typedef struct {
        logic [4:0]  wa;
        logic        regwe;
        logic [1:0]  cregwd;
        logic [31:0] alu;
        logic [31:0] memrd;
        logic        chk_md;
        logic        exc;
    } wb_t;

    mem_t mem_q[$];
    wb_t  wb_q[$];
    mem_t me;
    wb_t  we_exp;
    int total = 0;
    int bad = 0;
    int wait_cfg = 0;
    logic resp_ack = 1'b0;
    logic force_ack = 1'b0;
    logic [31:0] lb = 32'h0;

    assign mack_i = resp_ack | force_ack;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // memory model: ack in the (wait_cfg+1)th cycle of an outstanding request
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mreq_o && !resp_ack) begin
                if (cnt >= wait_cfg) resp_ack = 1'b1;
                else cnt++;
            end else begin
                resp_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && mreq_o && mack_i) begin
            if (mem_q.size() == 0) begin
                chk("mem_unexpected_req", {32'h0, maddr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                me = mem_q.pop_front();
                chk("maddr_o", maddr_o, me.addr);
                chk("mwdata_o", mwdata_o, me.wdata);
                chk("mbe_o", mbe_o, me.be);
                chk("mwe_o", mwe_o, me.we);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", {32'h0, aluout_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                we_exp = wb_q.pop_front();
                chk("wa_o", wa_o, we_exp.wa);
                chk("regwe_o", regwe_o, we_exp.regwe);
                chk("cregwd_o", cregwd_o, we_exp.cregwd);
                chk("aluout_o", aluout_o, we_exp.alu);
                if (we_exp.chk_md) chk("memrd_o", memrd_o, we_exp.memrd);
`ifdef MEM_ALIGN_CHK_EN
                chk("align_exc_o", align_exc_o, we_exp.exc);
`endif
            end
        end
    end

    task automatic set_op(input logic re, input logic wr, input logic sgn, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] rd2, input logic rwe,
                          input logic cwa, input logic [1:0] cwd, input logic [4:0] rt,
                          input logic [4:0] rd);
        valid_i = 1'b1; memre_i = re; memwe_i = wr; memsign_i = sgn; memlen_i = len;
        aluout_i = addr; rd2_i = rd2; regwe_i = rwe; cregwa_i = cwa; cregwd_i = cwd;
        rt_i = rt; rd_i = rd;
    endtask

    task automatic run(input int exp_stall, input bit chk_fwd, input logic exp_we,
                       input logic [4:0] exp_wa, input logic [31:0] exp_wd);
        int n;
        bit fw_early;
        n = 0;
        fw_early = 1'b0;
        @(negedge clk);
        while (stall_o && n < 50) begin
            n++;
            if (we_me) fw_early = 1'b1;
            @(negedge clk);
        end
        chk("stall_cycles", n, exp_stall);
        if (chk_fwd) begin
            if (exp_stall > 0) chk("we_me_during_stall", fw_early, 1'b0);
            chk("we_me", we_me, exp_we);
            chk("wa_me", wa_me, exp_wa);
            chk("wd_me", wd_me, exp_wd);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0; memre_i = 1'b0; memwe_i = 1'b0; regwe_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_i = 0; cregwa_i = 0; regwe_i = 0; memwe_i = 0; memre_i = 0;
        memsign_i = 0; cregwd_i = 0; memlen_i = 0; rd2_i = 0; aluout_i = 0; mrdata_i = 0;
        rt_i = 0; rd_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mreq", mreq_o, 0);
        chk("rst_mwe", mwe_o, 0);
        chk("rst_mbe", mbe_o, 0);
        chk("rst_maddr", maddr_o, 0);
        chk("rst_mwdata", mwdata_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_regwe_o", regwe_o, 0);
        chk("rst_wa_o", wa_o, 0);
        chk("rst_aluout_o", aluout_o, 0);
        chk("rst_memrd_o", memrd_o, 0);
`ifdef MEM_ALIGN_CHK_EN
        chk("rst_align_exc", align_exc_o, 0);
`endif
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // ALU op, rd selected
        set_op(0, 0, 0, 2'b10, 32'h1234, 0, 1, 1, 2'b00, 5'd7, 5'd5);
        wb_q.push_back('{5'd5, 1'b1, 2'b00, 32'h1234, lb, 1'b1, 1'b0});
        run(0, 1, 1'b1, 5'd5, 32'h1234);

        // store byte at 0x1003, two wait states
        wait_cfg = 2;
        set_op(0, 1, 0, 2'b00, 32'h1003, 32'hAB, 0, 0, 2'b00, 5'd9, 5'd0);
        mem_q.push_back('{32'h1000, 32'hABABABAB, 4'b1000, 1'b1});
        wb_q.push_back('{5'd9, 1'b0, 2'b00, 32'h1003, lb, 1'b1, 1'b0});
        run(4, 0, 1'b0, 5'd0, 32'h0);

        // signed half load at 0x2002
        wait_cfg = 1; mrdata_i = 32'h8001_0000;
        set_op(1, 0, 1, 2'b01, 32'h2002, 0, 1, 0, 2'b01, 5'd3, 5'd0);
        mem_q.push_back('{32'h2000, 32'h0, 4'b1100, 1'b0});
        lb = 32'hFFFF_8001;
        wb_q.push_back('{5'd3, 1'b1, 2'b01, 32'h2002, lb, 1'b1, 1'b0});
        run(3, 1, 1'b1, 5'd3, 32'hFFFF_8001);

        // unsigned half load, zero waits
        wait_cfg = 0;
        set_op(1, 0, 0, 2'b01, 32'h2002, 0, 1, 0, 2'b01, 5'd3, 5'd0);
        mem_q.push_back('{32'h2000, 32'h0, 4'b1100, 1'b0});
        lb = 32'h0000_8001;
        wb_q.push_back('{5'd3, 1'b1, 2'b01, 32'h2002, lb, 1'b1, 1'b0});
        run(2, 1, 1'b1, 5'd3, 32'h0000_8001);

        // signed byte at offset 1, unsigned byte at offset 3
        mrdata_i = 32'h1234_8056;
        set_op(1, 0, 1, 2'b00, 32'h4001, 0, 1, 0, 2'b01, 5'd4, 5'd0);
        mem_q.push_back('{32'h4000, 32'h0, 4'b0010, 1'b0});
        lb = 32'hFFFF_FF80;
        wb_q.push_back('{5'd4, 1'b1, 2'b01, 32'h4001, lb, 1'b1, 1'b0});
        run(2, 1, 1'b1, 5'd4, 32'hFFFF_FF80);
        set_op(1, 0, 0, 2'b00, 32'h4003, 0, 1, 0, 2'b01, 5'd4, 5'd0);
        mem_q.push_back('{32'h4000, 32'h0, 4'b1000, 1'b0});
        lb = 32'h0000_0012;
        wb_q.push_back('{5'd4, 1'b1, 2'b01, 32'h4003, lb, 1'b1, 1'b0});
        run(2, 1, 1'b1, 5'd4, 32'h12);

        // word load, three waits
        wait_cfg = 3; mrdata_i = 32'hDEAD_BEEF;
        set_op(1, 0, 0, 2'b10, 32'h3000, 0, 1, 1, 2'b01, 5'd1, 5'd8);
        mem_q.push_back('{32'h3000, 32'h0, 4'b1111, 1'b0});
        lb = 32'hDEAD_BEEF;
        wb_q.push_back('{5'd8, 1'b1, 2'b01, 32'h3000, lb, 1'b1, 1'b0});
        run(5, 1, 1'b1, 5'd8, 32'hDEAD_BEEF);

        // store half; load buffer must survive it
        wait_cfg = 1; mrdata_i = 32'h5555_5555;
        set_op(0, 1, 0, 2'b01, 32'h5002, 32'h5566_CAFE, 0, 0, 2'b00, 5'd2, 5'd0);
        mem_q.push_back('{32'h5000, 32'hCAFE_CAFE, 4'b1100, 1'b1});
        wb_q.push_back('{5'd2, 1'b0, 2'b00, 32'h5002, lb, 1'b1, 1'b0});
        run(3, 0, 1'b0, 5'd0, 32'h0);
        set_op(0, 0, 0, 2'b10, 32'h77, 0, 1, 1, 2'b01, 5'd0, 5'd6);
        wb_q.push_back('{5'd6, 1'b1, 2'b01, 32'h77, lb, 1'b1, 1'b0});
        run(0, 1, 1'b1, 5'd6, 32'hDEAD_BEEF);

        // word store
        wait_cfg = 0;
        set_op(0, 1, 0, 2'b10, 32'h6004, 32'h0102_0304, 0, 0, 2'b00, 5'd2, 5'd0);
        mem_q.push_back('{32'h6004, 32'h0102_0304, 4'b1111, 1'b1});
        wb_q.push_back('{5'd2, 1'b0, 2'b00, 32'h6004, lb, 1'b1, 1'b0});
        run(2, 0, 1'b0, 5'd0, 32'h0);

        // misaligned word load and half store
        mrdata_i = 32'hA1B2_C3D4;
`ifdef MEM_ALIGN_CHK_EN
        set_op(1, 0, 0, 2'b10, 32'h3001, 0, 1, 0, 2'b01, 5'd10, 5'd0);
        wb_q.push_back('{5'd10, 1'b0, 2'b01, 32'h3001, lb, 1'b1, 1'b1});
        run(0, 0, 1'b0, 5'd0, 32'h0);
        set_op(0, 1, 0, 2'b01, 32'h5001, 32'h7788, 0, 0, 2'b00, 5'd11, 5'd0);
        wb_q.push_back('{5'd11, 1'b0, 2'b00, 32'h5001, lb, 1'b1, 1'b1});
        run(0, 0, 1'b0, 5'd0, 32'h0);
`else
        set_op(1, 0, 0, 2'b10, 32'h3001, 0, 1, 0, 2'b01, 5'd10, 5'd0);
        mem_q.push_back('{32'h3000, 32'h0, 4'b1111, 1'b0});
        lb = 32'hA1B2_C3D4;
        wb_q.push_back('{5'd10, 1'b1, 2'b01, 32'h3001, lb, 1'b1, 1'b0});
        run(2, 1, 1'b1, 5'd10, 32'hA1B2_C3D4);
        set_op(0, 1, 0, 2'b01, 32'h5001, 32'h7788, 0, 0, 2'b00, 5'd11, 5'd0);
        mem_q.push_back('{32'h5000, 32'h7788_7788, 4'b0011, 1'b1});
        wb_q.push_back('{5'd11, 1'b0, 2'b00, 32'h5001, lb, 1'b1, 1'b0});
        run(2, 0, 1'b0, 5'd0, 32'h0);
`endif

        // reset in the second ACCESS cycle, then a stray ack
        wait_cfg = 20;
        set_op(1, 0, 0, 2'b10, 32'h7000, 0, 1, 0, 2'b01, 5'd12, 5'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_mreq_before", mreq_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 0; memre_i = 0; regwe_i = 0;
        @(negedge clk);
        chk("abort_mreq_after", mreq_o, 0);
        chk("abort_valid_o", valid_o, 0);
        chk("abort_stall", stall_o, 0);
        wait_cfg = 0;
        @(posedge clk); #1; force_ack = 1'b1;
        @(posedge clk); #1; force_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_mreq", mreq_o, 0);
        chk("late_ack_stall", stall_o, 0);
        @(posedge clk); #1;
        set_op(0, 0, 0, 2'b10, 32'hBEEF, 0, 1, 1, 2'b00, 5'd0, 5'd13);
        wb_q.push_back('{5'd13, 1'b1, 2'b00, 32'hBEEF, 32'h0, 1'b0, 1'b0});
        run(0, 1, 1'b1, 5'd13, 32'hBEEF);

        repeat (3) @(negedge clk);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised memory-access pipeline stage; successor of the single-cycle MEM stage. It sits between EX/MEM and MEM/WB and drives an external data memory over a req/ack handshake with wait states, so it replaces the built-in single-cycle Dmem. It adds sub-word stores via byte enables and signed/unsigned sub-word loads. It stalls upstream stages while an access is outstanding and publishes a forwarding tap for the hazard unit.

## Interface
- DATA_W, 32: datapath width, 32 or 64; lanes NB = DATA_W/8, offset bits OB = log2(NB)
- REG_AW, 5: register-address width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  instruction present in EX/MEM
- cregwa_i  in  1  1 = write rd_i, 0 = write rt_i
- cregwd_i  in  2  00 = ALU result, 01 = memory read data, others = 0
- regwe_i, memwe_i, memre_i, memsign_i  in  1 each  reg write; store; load; sign-extend load
- memlen_i  in  2  00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only; else treated as word)
- rd2_i, aluout_i  in  DATA_W  store data; address/ALU result
- rt_i, rd_i  in  REG_AW  destination candidates
- mreq_o, mwe_o  out  1  memory request; write
- maddr_o, mwdata_o  out  DATA_W  lane-aligned address; lane-placed store data
- mbe_o  out  NB  byte enables
- mack_i  in  1  access complete; mrdata_i valid
- mrdata_i  in  DATA_W  raw read data
- stall_o  out  1  freeze PC/IF/ID/EX and EX/MEM
- we_me, wa_me, wd_me  out  1/REG_AW/DATA_W  forwarding tap
- valid_o, regwe_o, cregwd_o, wa_o, aluout_o, memrd_o  out  MEM/WB register

## Operation
- Memory op = valid_i & (memre_i | memwe_i); upstream holds all inputs stable while stall_o=1.
- wa = cregwa_i ? rd_i : rt_i. Offset off = aluout_i[OB-1:0], little-endian.
- maddr_o = aluout_i with low OB bits zeroed. mwdata_o = rd2_i low bytes replicated across lanes. mbe_o = size mask (1/3/F/FF) << off.
- Load: shift mrdata_i right by 8*off, keep size bits, sign-extend if memsign_i, else zero-extend; result captured into load buffer on mack_i.
- FSM:
  - IDLE: memory op -> ACCESS, stall_o=1; otherwise stall_o=0.
  - ACCESS: mreq_o=1, mwe_o=memwe_i, stall_o=1; mack_i -> DONE.
  - DONE: stall_o=0, result enters MEM/WB -> IDLE.
- MEM/WB register updates when stall_o=0. It loads a bubble (valid_o=0, regwe_o=0) while stall_o=1. wa_o=wa; memrd_o=load buffer.
- Forwarding: we_me = valid_i & regwe_i & !(memre_i & state!=DONE). wa_me = wa. wd_me = ALU result, load buffer, or 0 per cregwd_i.
- mack_i outside ACCESS ignored. Store with memre_i=0 leaves load buffer unchanged.

## Timing
- Reset: state IDLE. All outputs 0: mreq_o, mwe_o, mbe_o, maddr_o, mwdata_o, stall_o, MEM/WB fields, align_exc_o.
- Non-memory instruction: 1 cycle, no stall.
- Memory op with W wait cycles (ack in (W+1)th ACCESS cycle): stall_o high for W+2 cycles; result at MEM/WB one edge after DONE.
- mreq_o stays high until mack_i; request fields constant while high.
- rst during ACCESS: next cycle mreq_o=0, state IDLE, no MEM/WB update; memory tolerates abandoned request.
- Back-to-back memory ops: DONE -> IDLE -> ACCESS; min 1 non-stalled cycle between them.

## Configuration
- MEM_ALIGN_CHK_EN defined:
  - Misaligned access (half off[0]!=0, word off[1:0]!=0, dword off!=0) issues no request and causes no stall.
  - Instruction passes in 1 cycle with regwe_o=0 and align_exc_o=1 registered alongside valid_o.
- Undefined: no align_exc_o port. Offset is masked down to the access size (forced alignment) and the access proceeds.

## Test plan
- Reset, then add aluout_i=0x1234, cregwd_i=00, cregwa_i=1, rd_i=5 -> next edge wa_o=5, regwe_o=1, stall_o never asserted.
- Store byte rd2_i=0xAB at 0x1003, ack after 2 waits -> mbe_o=4'b1000, mwdata_o=0xABABABAB, stall_o high 4 cycles.
- Load half, memsign_i=1, addr 0x2002, mrdata_i=0x8001_0000 -> memrd_o=0xFFFF8001; memsign_i=0 -> 0x00008001.
- Load followed by dependent op: we_me=0 until DONE, then wd_me=load value and we_me=1.
- rst asserted in 2nd ACCESS cycle -> mreq_o=0 next cycle, valid_o=0; a late mack_i is ignored.
- MEM_ALIGN_CHK_EN on, load word at 0x3001 -> mreq_o stays 0, align_exc_o=1, regwe_o=0 after 1 cycle.
